// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//   Two-port round-robin arbiter in front of a single-port 64 x 32-bit
//   synchronous RAM. Each requester issues word or byte reads and writes.
//   The arbiter serialises the accesses and returns a one-cycle done pulse
//   to the requester that was served.
//
// Configuration macro:
//   MEM_BYTE_WRITE_EN  defined   : byte writes use read-modify-write
//                                  (RMW_ADDR -> RMW_DATA -> WR -> DONE).
//                      undefined : a byte write is rejected. It goes
//                                  IDLE -> DONE with err set, and the RAM
//                                  is not accessed.
//
// Ports:
//   clk_m            in   1   clock, rising edge
//   rst              in   1   synchronous active-high reset
//   req0/req1        in   1   request, held until done
//   we0/we1          in   1   1 = write, 0 = read
//   bm0/bm1          in   1   1 = byte access, 0 = word access
//   addr0/addr1      in   8   byte address ([7:2] word, [1:0] lane)
//   wdata0/wdata1    in   32  write data (byte writes use [7:0])
//   done             out  2   one-cycle completion pulse per requester
//   rd_data          out  32  last read result
//   err              out  1   rejected-request flag, pulses with done
//   ram_we           out  1   RAM write enable
//   ram_addr         out  6   RAM word address
//   ram_din          out  32  RAM write data
//   ram_dout         in   32  RAM read data, one cycle after ram_addr
module mem_access_arbiter (
  input  logic        clk_m,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        bm0,
  input  logic        bm1,
  input  logic [7:0]  addr0,
  input  logic [7:0]  addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  done,
  output logic [31:0] rd_data,
  output logic        err,
  output logic        ram_we,
  output logic [5:0]  ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ADDR  = 3'd1,
    RD_DATA  = 3'd2,
    WR       = 3'd3,
    DONE     = 3'd4
`ifdef MEM_BYTE_WRITE_EN
    ,
    RMW_ADDR = 3'd5,
    RMW_DATA = 3'd6
`endif
  } state_e;

  state_e      state_q;
  logic [1:0]  done_q;
  logic        err_q;
  logic [31:0] rd_data_q;
  logic        ram_we_q;
  logic [5:0]  ram_addr_q;
  logic [31:0] ram_din_q;
  logic        last_q;      // id of the most recent grant
  logic        id_q;        // id of the access in flight
  logic        bm_q;
  logic [1:0]  lane_q;
`ifdef MEM_BYTE_WRITE_EN
  logic [7:0]  wbyte_q;
`endif

  logic        gnt_d;
  logic        sel_we_d;
  logic        sel_bm_d;
  logic [7:0]  sel_addr_d;
  logic [31:0] sel_wdata_d;

  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lane);
    logic [7:0] b;
    case (lane)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
    endcase
    return {24'h000000, b};
  endfunction

`ifdef MEM_BYTE_WRITE_EN
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
    logic [31:0] m;
    m = word;
    case (lane)
      2'd0: m[7:0]   = b;
      2'd1: m[15:8]  = b;
      2'd2: m[23:16] = b;
      2'd3: m[31:24] = b;
    endcase
    return m;
  endfunction
`endif

  // Round-robin: on a tie the port that was not served last wins.
  // last_q resets to 1, so port 0 wins the first tie.
  always_comb begin
    gnt_d = 1'b0;
    if (req0 && req1) begin
      gnt_d = ~last_q;
    end else if (req1) begin
      gnt_d = 1'b1;
    end
    sel_we_d    = gnt_d ? we1    : we0;
    sel_bm_d    = gnt_d ? bm1    : bm0;
    sel_addr_d  = gnt_d ? addr1  : addr0;
    sel_wdata_d = gnt_d ? wdata1 : wdata0;
  end

  always_ff @(posedge clk_m) begin
    if (rst) begin
      state_q    <= IDLE;
      done_q     <= 2'b00;
      err_q      <= 1'b0;
      rd_data_q  <= 32'h0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= 6'h0;
      ram_din_q  <= 32'h0;
      last_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            id_q       <= gnt_d;
            last_q     <= gnt_d;
            bm_q       <= sel_bm_d;
            lane_q     <= sel_addr_d[1:0];
            ram_addr_q <= sel_addr_d[7:2];
            if (!sel_we_d) begin
              state_q <= RD_ADDR;
            end else if (!sel_bm_d) begin
              // Word write: the RAM is written in the very next cycle.
              ram_we_q  <= 1'b1;
              ram_din_q <= sel_wdata_d;
              state_q   <= WR;
            end else begin
`ifdef MEM_BYTE_WRITE_EN
              wbyte_q <= sel_wdata_d[7:0];
              state_q <= RMW_ADDR;
`else
              // Byte writes are not supported in this build: reject at once.
              done_q  <= id_onehot(gnt_d);
              err_q   <= 1'b1;
              state_q <= DONE;
`endif
            end
          end
        end
        RD_ADDR: begin
          state_q <= RD_DATA;
        end
        RD_DATA: begin
          rd_data_q <= bm_q ? lane_extract(ram_dout, lane_q) : ram_dout;
          done_q    <= id_onehot(id_q);
          state_q   <= DONE;
        end
`ifdef MEM_BYTE_WRITE_EN
        RMW_ADDR: begin
          state_q <= RMW_DATA;
        end
        RMW_DATA: begin
          ram_din_q <= lane_merge(ram_dout, lane_q, wbyte_q);
          ram_we_q  <= 1'b1;
          state_q   <= WR;
        end
`endif
        WR: begin
          ram_we_q <= 1'b0;
          done_q   <= id_onehot(id_q);
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= 2'b00;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign err      = err_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;

`ifdef MEM_BYTE_WRITE_EN
  localparam bit BW = 1'b1;
`else
  localparam bit BW = 1'b0;
`endif

  logic        clk_m = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic        bm0 = 1'b0, bm1 = 1'b0;
  logic [7:0]  addr0 = 8'h0, addr1 = 8'h0;
  logic [31:0] wdata0 = 32'h0, wdata1 = 32'h0;
  logic [1:0]  done;
  logic [31:0] rd_data;
  logic        err;
  logic        ram_we;
  logic [5:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic        mem_clr = 1'b1;
  logic [31:0] mem [64];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_m = ~clk_m;

  mem_access_arbiter dut (
    .clk_m(clk_m), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .bm0(bm0), .bm1(bm1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done(done), .rd_data(rd_data), .err(err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Synchronous RAM model; untouched words hold 0xC0DE0000 | index.
  always @(posedge clk_m) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    bit          port;
    bit          we;
    bit          bm;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rd;
    bit          er;
    int          wcnt;
    logic [31:0] wdin;
  } vec_t;

  function automatic vec_t mk(bit port, bit we, bit bm, logic [7:0] addr,
                              logic [31:0] wdata, int lat, logic [31:0] rd,
                              bit er, int wcnt, logic [31:0] wdin);
    vec_t v;
    v.port = port; v.we = we; v.bm = bm; v.addr = addr; v.wdata = wdata;
    v.lat = lat; v.rd = rd; v.er = er; v.wcnt = wcnt; v.wdin = wdin;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h, required %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_m);
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk_m);
    rst = 1'b0;
  endtask

  // Issue one access from a single requester and check everything it does.
  task automatic run_vec(input vec_t v, input string tag);
    int          lat, wcnt;
    logic [1:0]  dn;
    logic        er;
    logic [31:0] rd, wdi;
    logic [5:0]  wad, a1;
    lat = 0; wcnt = 0; dn = 2'b00; er = 1'b0; rd = 32'h0; wdi = 32'h0;
    wad = 6'h0; a1 = 6'h0;
    @(negedge clk_m);
    if (v.port) begin
      req1 = 1'b1; we1 = v.we; bm1 = v.bm; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; we0 = v.we; bm0 = v.bm; addr0 = v.addr; wdata0 = v.wdata;
    end
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_m);
      if (c == 1) a1 = ram_addr;
      if (ram_we) begin
        wcnt++;
        wad = ram_addr;
        wdi = ram_din;
      end
      if (done != 2'b00) begin
        lat = c; dn = done; er = err; rd = rd_data;
        break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " done"}, {30'h0, dn}, v.port ? 32'd2 : 32'd1);
    chk({tag, " err"}, {31'h0, er}, {31'h0, v.er});
    chk({tag, " rd_data"}, rd, v.rd);
    chk({tag, " ram_addr"}, {26'h0, a1}, {26'h0, v.addr[7:2]});
    chk({tag, " write count"}, wcnt, v.wcnt);
    chk({tag, " ram_din"}, wdi, v.wdin);
    chk({tag, " write addr"}, {26'h0, wad},
        (v.wcnt != 0) ? {26'h0, v.addr[7:2]} : 32'h0);
    @(negedge clk_m);
    chk({tag, " done one cycle"}, {30'h0, done}, 32'h0);
  endtask

  vec_t        vecs [13];
  logic [1:0]  seq  [4];
  logic [31:0] rseq [4];

  initial begin
    // port we bm addr wdata | lat rd err wcnt wdin
    vecs[0]  = mk(0, 1, 0, 8'h04, 32'hAA55CC33, 2, 32'h00000000, 0, 1, 32'hAA55CC33);
    vecs[1]  = mk(1, 0, 1, 8'h06, 32'h0, 3, 32'h00000055, 0, 0, 32'h0);
    vecs[2]  = mk(0, 0, 0, 8'h04, 32'h0, 3, 32'hAA55CC33, 0, 0, 32'h0);
    vecs[3]  = mk(1, 0, 1, 8'h04, 32'h0, 3, 32'h00000033, 0, 0, 32'h0);
    vecs[4]  = mk(0, 0, 1, 8'h07, 32'h0, 3, 32'h000000AA, 0, 0, 32'h0);
    vecs[5]  = mk(1, 1, 1, 8'h07, 32'h000000EE, BW ? 4 : 1, 32'h000000AA,
                  !BW, BW ? 1 : 0, BW ? 32'hEE55CC33 : 32'h0);
    vecs[6]  = mk(0, 0, 0, 8'h04, 32'h0, 3,
                  BW ? 32'hEE55CC33 : 32'hAA55CC33, 0, 0, 32'h0);
    vecs[7]  = mk(1, 0, 0, 8'hFC, 32'h0, 3, 32'hC0DE003F, 0, 0, 32'h0);
    vecs[8]  = mk(1, 1, 0, 8'hFD, 32'h12345678, 2, 32'hC0DE003F, 0, 1, 32'h12345678);
    vecs[9]  = mk(0, 0, 1, 8'hFF, 32'h0, 3, 32'h00000012, 0, 0, 32'h0);
    vecs[10] = mk(0, 1, 1, 8'h00, 32'hFFFFFF77, BW ? 4 : 1, 32'h00000012,
                  !BW, BW ? 1 : 0, BW ? 32'hC0DE0077 : 32'h0);
    vecs[11] = mk(1, 0, 0, 8'h00, 32'h0, 3,
                  BW ? 32'hC0DE0077 : 32'hC0DE0000, 0, 0, 32'h0);
    vecs[12] = mk(1, 0, 1, 8'h02, 32'h0, 3, 32'h000000DE, 0, 0, 32'h0);

    // Reset state
    repeat (3) @(negedge clk_m);
    mem_clr = 1'b0;
    chk("reset done", {30'h0, done}, 32'h0);
    chk("reset err", {31'h0, err}, 32'h0);
    chk("reset rd_data", rd_data, 32'h0);
    chk("reset ram_we", {31'h0, ram_we}, 32'h0);
    chk("reset ram_addr", {26'h0, ram_addr}, 32'h0);
    chk("reset ram_din", ram_din, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Both requesters held for four accesses: grants alternate from port 0.
    do_reset();
    begin
      int k, ov;
      k = 0; ov = 0;
      @(negedge clk_m);
      req0 = 1'b1; we0 = 1'b0; bm0 = 1'b0; addr0 = 8'h08;
      req1 = 1'b1; we1 = 1'b0; bm1 = 1'b0; addr1 = 8'h0C;
      for (int c = 0; c < 40 && k < 4; c++) begin
        @(negedge clk_m);
        if (done == 2'b11) ov++;
        if (done != 2'b00) begin
          seq[k] = done; rseq[k] = rd_data; k++;
        end
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("rr count", k, 4);
      chk("rr overlap", ov, 0);
      for (int j = 0; j < k; j++) begin
        chk($sformatf("rr grant %0d", j), {30'h0, seq[j]},
            (j % 2 == 0) ? 32'd1 : 32'd2);
        chk($sformatf("rr rd_data %0d", j), rseq[j],
            (j % 2 == 0) ? 32'hC0DE0002 : 32'hC0DE0003);
      end
      repeat (2) @(negedge clk_m);
    end

    // Reset during RD_DATA aborts the read.
    @(negedge clk_m);
    req0 = 1'b1; we0 = 1'b0; bm0 = 1'b0; addr0 = 8'h08;
    repeat (2) @(negedge clk_m);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk_m);
    chk("abort done", {30'h0, done}, 32'h0);
    chk("abort rd_data", rd_data, 32'h0);
    chk("abort ram_we", {31'h0, ram_we}, 32'h0);
    chk("abort err", {31'h0, err}, 32'h0);
    rst = 1'b0;
    run_vec(mk(0, 0, 0, 8'h0C, 32'h0, 3, 32'hC0DE0003, 0, 0, 32'h0), "post-abort");

    // Reset while in WR drops ram_we on the following cycle.
    @(negedge clk_m);
    req1 = 1'b1; we1 = 1'b1; bm1 = 1'b0; addr1 = 8'h10; wdata1 = 32'hDEADBEEF;
    @(negedge clk_m);
    chk("wr ram_we", {31'h0, ram_we}, 32'h1);
    rst = 1'b1; req1 = 1'b0;
    @(negedge clk_m);
    chk("wr abort ram_we", {31'h0, ram_we}, 32'h0);
    chk("wr abort done", {30'h0, done}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk_m);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
